// File: rtl/ctrl_pkg.sv
// Shared definitions for the single-bus RISC control sequencer:
// opcodes, instruction classes, FSM states and instruction field positions.
package ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Address generation and ldi both use the adder.
  localparam logic [4:0] ALU_ADD = OP_ADD;

  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int C_HI  = 18;
  localparam int C_LO  = 0;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_ITYPE, CL_LDI, CL_LD, CL_ST, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational opcode classifier feeding the sequencer's execute steps.
module ctrl_op_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps this purely combinational (no latch).
    op_class = CL_ILLEGAL;
    case (opcode)
      OPW'(OP_LD):   op_class = CL_LD;
      OPW'(OP_LDI):  op_class = CL_LDI;
      OPW'(OP_ST):   op_class = CL_ST;
      OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR),
      OPW'(OP_SHR), OPW'(OP_SHL), OPW'(OP_ROR), OPW'(OP_ROL):
                     op_class = CL_RTYPE;
      OPW'(OP_ADDI), OPW'(OP_ANDI), OPW'(OP_ORI):
                     op_class = CL_ITYPE;
      OPW'(OP_NOP):  op_class = CL_NOP;
      OPW'(OP_HALT): op_class = CL_HALT;
      default:       op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit stepping T0..T7 per instruction with memory ready handshake.
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW          = 5,
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        stop,
  input  logic        mem_done,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlo_out,
  output logic        c_out,
  output logic        read,
  output logic        write,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        ba_out,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        fault,
  output logic [31:0] retired
);

  localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WW-1:0] WLIM = WW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  logic [OPW-1:0] opcode;
  op_class_t      op_class;
  state_t         state, state_nxt;
  logic           fault_q, fault_set, stop_pend, retire, mem_wait, timeout;
  logic [WW-1:0]  wcnt;

  assign opcode = ir[31 -: OPW];

  ctrl_op_decode #(.OPW(OPW)) u_decode (
    .opcode  (opcode),
    .op_class(op_class)
  );

  assign mem_wait = (state == S_T1) ||
                    (state == S_T6 && op_class == CL_LD) ||
                    (state == S_T7 && op_class == CL_ST);
  assign timeout  = (MEM_WAIT_MAX != 0) && (wcnt == WLIM) && !mem_done;

  always_comb begin
    state_nxt = state;
    fault_set = 1'b0;
    retire    = 1'b0;
    case (state)
      S_RST: state_nxt = S_T0;
      S_T0:  state_nxt = (stop || stop_pend) ? S_HALT : S_T1;
      S_T1: begin
        if (mem_done)     state_nxt = S_T2;
        else if (timeout) begin state_nxt = S_HALT; fault_set = 1'b1; end
      end
      S_T2: state_nxt = S_T3;
      S_T3: begin
        case (op_class)
          CL_NOP:     begin state_nxt = S_T0; retire = 1'b1; end
          CL_HALT:    state_nxt = S_HALT;
          CL_ILLEGAL: begin state_nxt = S_HALT; fault_set = 1'b1; end
          default:    state_nxt = S_T4;
        endcase
      end
      S_T4: state_nxt = S_T5;
      S_T5: begin
        if (op_class == CL_LD || op_class == CL_ST) state_nxt = S_T6;
        else begin state_nxt = S_T0; retire = 1'b1; end
      end
      S_T6: begin
        if (op_class != CL_LD || mem_done) state_nxt = S_T7;
        else if (timeout) begin state_nxt = S_HALT; fault_set = 1'b1; end
      end
      S_T7: begin
        if (op_class != CL_ST || mem_done) begin state_nxt = S_T0; retire = 1'b1; end
        else if (timeout) begin state_nxt = S_HALT; fault_set = 1'b1; end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RST;
      fault_q   <= 1'b0;
      stop_pend <= 1'b0;
      wcnt      <= '0;
    end else begin
      state     <= state_nxt;
      fault_q   <= fault_q | fault_set;
      // A stop seen mid-instruction is remembered until the next T0 consumes it.
      stop_pend <= (state == S_T0) ? 1'b0 : (stop_pend | stop);
      if (state_nxt != state) wcnt <= '0;
      else if (mem_wait)      wcnt <= wcnt + WW'(1);
    end
  end

  always_comb begin
    {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out,
     c_out, read, write, gra, grb, grc, r_in, r_out, ba_out} = '0;
    alu_op = '0;
    case (state)
      S_T0: {pc_out, mar_in, inc_pc, z_in} = '1;
      S_T1: {zlo_out, pc_in, read, mdr_in} = '1;
      S_T2: {mdr_out, ir_in} = '1;
      S_T3: begin
        if (op_class == CL_RTYPE || op_class == CL_ITYPE) {grb, r_out, y_in} = '1;
        else if (op_class == CL_LDI || op_class == CL_LD || op_class == CL_ST)
          {grb, ba_out, y_in} = '1;
      end
      S_T4: begin
        z_in = 1'b1;
        if (op_class == CL_RTYPE) begin
          {grc, r_out} = '1;
          alu_op = 5'(opcode);
        end else if (op_class == CL_ITYPE) begin
          c_out  = 1'b1;
          alu_op = 5'(opcode);
        end else begin
          c_out  = 1'b1;
          alu_op = ALU_ADD;
        end
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (op_class == CL_LD || op_class == CL_ST) mar_in = 1'b1;
        else {gra, r_in} = '1;
      end
      S_T6: begin
        mdr_in = 1'b1;
        if (op_class == CL_LD) read = 1'b1;
        else {gra, r_out} = '1;
      end
      S_T7: begin
        if (op_class == CL_LD) {mdr_out, gra, r_in} = '1;
        else write = 1'b1;
      end
      default: ;
    endcase
  end

  assign run   = (state != S_HALT);
  assign fault = fault_q;

  // Register fields are routed by the datapath's select/encode logic, not here.
  logic unused_fields;
  assign unused_fields = ^{ir[RA_HI:RA_LO], ir[RB_HI:RB_LO], ir[RC_HI:RC_LO], ir[C_HI:C_LO]};

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end
  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired       = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: stimulus pushes per-cycle
// expectations from a step-table model, a negedge monitor pops and compares.
module tb_control_sequencer;

  localparam int WAITMAX = 4;
`ifdef CTRL_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  localparam logic [18:0] PC_OUT  = 19'd1 << 0;
  localparam logic [18:0] PC_IN   = 19'd1 << 1;
  localparam logic [18:0] INC_PC  = 19'd1 << 2;
  localparam logic [18:0] MAR_IN  = 19'd1 << 3;
  localparam logic [18:0] MDR_IN  = 19'd1 << 4;
  localparam logic [18:0] MDR_OUT = 19'd1 << 5;
  localparam logic [18:0] IR_IN   = 19'd1 << 6;
  localparam logic [18:0] Y_IN    = 19'd1 << 7;
  localparam logic [18:0] Z_IN    = 19'd1 << 8;
  localparam logic [18:0] ZLO_OUT = 19'd1 << 9;
  localparam logic [18:0] C_OUT   = 19'd1 << 10;
  localparam logic [18:0] READ    = 19'd1 << 11;
  localparam logic [18:0] WRITE   = 19'd1 << 12;
  localparam logic [18:0] GRA     = 19'd1 << 13;
  localparam logic [18:0] GRB     = 19'd1 << 14;
  localparam logic [18:0] GRC     = 19'd1 << 15;
  localparam logic [18:0] R_IN    = 19'd1 << 16;
  localparam logic [18:0] R_OUT   = 19'd1 << 17;
  localparam logic [18:0] BA_OUT  = 19'd1 << 18;

  typedef enum {K_R, K_I, K_LDI, K_LD, K_ST, K_NOP, K_HALT, K_ILL} kind_t;

  typedef struct {
    logic [18:0] strb;
    logic        run;
    logic        fault;
    logic        chk_alu;
    logic [4:0]  alu;
    logic [31:0] ret;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ir = '0;
  logic        stop = 1'b0;
  logic        mem_done = 1'b1;
  logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out;
  logic read, write, gra, grb, grc, r_in, r_out, ba_out, run, fault;
  logic [4:0]  alu_op;
  logic [31:0] retired;
  logic [18:0] act_strb;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        expq[$];
  logic [31:0] m_ret = '0;
  bit          m_fault = 1'b0;
  bit          m_stop = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  control_sequencer #(.OPW(5), .MEM_WAIT_MAX(WAITMAX)) dut (
    .clock(clock), .reset_n(reset_n), .ir(ir), .stop(stop), .mem_done(mem_done),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out),
    .c_out(c_out), .read(read), .write(write), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .alu_op(alu_op), .run(run),
    .fault(fault), .retired(retired)
  );

  assign act_strb = {ba_out, r_out, r_in, grc, grb, gra, write, read, c_out, zlo_out,
                     z_in, y_in, ir_in, mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (expq.size() != 0) begin
      mon_e = expq.pop_front();
      check($sformatf("strobes@%0d", cyc), 32'(act_strb), 32'(mon_e.strb));
      check($sformatf("run@%0d", cyc), 32'(run), 32'(mon_e.run));
      check($sformatf("fault@%0d", cyc), 32'(fault), 32'(mon_e.fault));
      check($sformatf("retired@%0d", cyc), retired, mon_e.ret);
      if (mon_e.chk_alu) check($sformatf("alu_op@%0d", cyc), 32'(alu_op), 32'(mon_e.alu));
    end
  end

  function automatic kind_t kind_of(input logic [4:0] op);
    if (op == 5'd0)                 return K_LD;
    if (op == 5'd1)                 return K_LDI;
    if (op == 5'd2)                 return K_ST;
    if (op >= 5'd3 && op <= 5'd10)  return K_R;
    if (op >= 5'd11 && op <= 5'd13) return K_I;
    if (op == 5'd26)                return K_NOP;
    if (op == 5'd27)                return K_HALT;
    return K_ILL;
  endfunction

  task automatic push(input logic [18:0] m, input bit run_e, input bit chk_alu = 1'b0,
                      input logic [4:0] a = 5'd0);
    exp_t e;
    e.strb = m; e.run = run_e; e.fault = m_fault; e.chk_alu = chk_alu; e.alu = a;
    e.ret = RET_EN ? m_ret : 32'd0;
    expq.push_back(e);
  endtask

  // One non-waiting cycle; mem_done is randomized since it must be ignored here.
  task automatic step(input logic [18:0] m, input bit chk_alu = 1'b0, input logic [4:0] a = 5'd0);
    mem_done = 1'($urandom_range(0, 1));
    push(m, 1'b1, chk_alu, a);
    @(posedge clock); #1;
  endtask

  // Memory step: mem_done arrives after d held cycles, or never within WAITMAX.
  task automatic wstep(input logic [18:0] m, input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAITMAX; i++) begin
      mem_done = (i == d);
      push(m, 1'b1);
      @(posedge clock); #1;
      if (i == d) begin ok = 1'b1; return; end
    end
  endtask

  task automatic halt_cycles(input bit f);
    m_fault = m_fault | f;
    for (int i = 0; i < 3; i++) begin
      mem_done = 1'($urandom_range(0, 1));
      stop     = 1'($urandom_range(0, 1));
      push(19'd0, 1'b0);
      @(posedge clock); #1;
    end
  endtask

  // Reset asserted mid-cycle (checked immediately), then one RST cycle after release.
  task automatic do_reset();
    reset_n = 1'b0;
    stop = 1'b0; m_ret = '0; m_fault = 1'b0; m_stop = 1'b0;
    push(19'd0, 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    mem_done = 1'b1;
    push(19'd0, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic do_instr(input logic [31:0] word, input int fd, input int md,
                          input bit stop_t4, output bit halted);
    kind_t k;
    bit    ok;
    logic [4:0] op;
    halted = 1'b0;
    ir = word;
    op = word[31:27];
    k  = kind_of(op);
    step(PC_OUT | MAR_IN | INC_PC | Z_IN);
    if (m_stop) begin halt_cycles(1'b0); halted = 1'b1; return; end
    wstep(ZLO_OUT | PC_IN | READ | MDR_IN, fd, ok);
    if (!ok) begin halt_cycles(1'b1); halted = 1'b1; return; end
    step(MDR_OUT | IR_IN);
    case (k)
      K_R, K_I:         step(GRB | R_OUT | Y_IN);
      K_LDI, K_LD, K_ST: step(GRB | BA_OUT | Y_IN);
      K_NOP:            begin step(19'd0); m_ret++; return; end
      K_HALT:           begin step(19'd0); halt_cycles(1'b0); halted = 1'b1; return; end
      default:          begin step(19'd0); halt_cycles(1'b1); halted = 1'b1; return; end
    endcase
    stop = stop_t4;
    m_stop = m_stop | stop_t4;
    case (k)
      K_R:     step(GRC | R_OUT | Z_IN, 1'b1, op);
      K_I:     step(C_OUT | Z_IN, 1'b1, op);
      default: step(C_OUT | Z_IN, 1'b1, 5'b00011);
    endcase
    stop = 1'b0;
    if (k == K_R || k == K_I || k == K_LDI) begin
      step(ZLO_OUT | GRA | R_IN);
      m_ret++;
      return;
    end
    step(ZLO_OUT | MAR_IN);
    if (k == K_LD) begin
      wstep(READ | MDR_IN, md, ok);
      if (!ok) begin halt_cycles(1'b1); halted = 1'b1; return; end
      step(MDR_OUT | GRA | R_IN);
    end else begin
      step(GRA | R_OUT | MDR_IN);
      wstep(WRITE, md, ok);
      if (!ok) begin halt_cycles(1'b1); halted = 1'b1; return; end
    end
    m_ret++;
  endtask

  function automatic int pick_delay();
    return ($urandom_range(0, 15) == 0) ? WAITMAX : $urandom_range(0, WAITMAX - 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    logic [4:0] legal [15];
    logic [4:0] op;
    int r;
    for (int i = 0; i < 14; i++) legal[i] = 5'(i);
    legal[14] = 5'b11010;

    @(posedge clock); #1;
    do_reset();

    do_instr(32'h18918000, 0, 0, 1'b0, h);
    do_instr(32'h00900010, 0, 3, 1'b0, h);

    // Stop pulsed in T4 of addi: instruction retires, next T0 halts.
    do_instr({5'b01011, 27'($urandom)}, 1, 0, 1'b1, h);
    do_instr({5'b00011, 27'($urandom)}, 0, 0, 1'b0, h);
    check("stop_halted", 32'(h), 32'd1);
    do_reset();

    // Fetch never completes: timeout fault after WAITMAX cycles in T1.
    do_instr({5'b00011, 27'($urandom)}, WAITMAX, 0, 1'b0, h);
    check("timeout_halted", 32'(h), 32'd1);
    do_reset();

    do_instr({5'b11111, 27'($urandom)}, 0, 0, 1'b0, h);
    check("illegal_halted", 32'(h), 32'd1);
    do_reset();

    do_instr({5'b11011, 27'($urandom)}, 2, 0, 1'b0, h);
    check("halt_halted", 32'(h), 32'd1);
    do_reset();

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      if (r < 90)      op = legal[$urandom_range(0, 14)];
      else if (r < 94) op = 5'b11011;
      else if (r < 97) op = 5'($urandom_range(14, 25));
      else             op = 5'($urandom_range(28, 31));
      do_instr({op, 27'($urandom)}, pick_delay(), pick_delay(), 1'b0, h);
      if (h) do_reset();
    end

    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit for the single-bus RISC datapath.
- Drives the register select/encode interface (Gra, Grb, Grc, Rin, Rout, BAout) and the datapath strobes for fetch and execute.
- Moore FSM stepping T0..T7 per instruction; memory accesses use a ready handshake.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- MEM_WAIT_MAX, 16, max cycles to wait for mem_done before a fault halt; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ir  in  32  instruction register contents.
- stop  in  1  halt request, sampled in T0.
- mem_done  in  1  memory completes current Read/Write.
- pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out  out  1 each  datapath strobes.
- read, write  out  1 each  memory strobes.
- gra, grb, grc, r_in, r_out, ba_out  out  1 each  register select/encode controls.
- alu_op  out  5  ALU operation code; equals the opcode, except ADD for address/ldi.
- run  out  1  high while executing.
- fault  out  1  sticky: illegal opcode or memory timeout.
- retired  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Opcodes:
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=00101, or=00110, shr=00111, shl=01000, ror=01001, rol=01010
  - addi=01011, andi=01100, ori=01101
  - nop=11010, halt=11011
  - all others illegal.
- States: RST, T0..T7, HALT. Outputs decode from the state register only; every strobe is 0 in RST and HALT.
- Reset: async entry to RST; run=1, fault=0, wait counter=0. The first clock edge after release goes to T0.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlo_out, pc_in, read, mdr_in.
  - T2: mdr_out, ir_in.
- T0 with stop=1 goes to HALT (run=0) instead of starting a fetch. stop raised mid-instruction lets the instruction finish; the halt takes effect at the next T0.
- R-type:
  - T3: grb, r_out, y_in.
  - T4: grc, r_out, alu_op=opcode, z_in.
  - T5: zlo_out, gra, r_in; then T0.
- I-type (addi/andi/ori):
  - T3 as R-type.
  - T4: c_out, alu_op=opcode, z_in.
  - T5 as R-type.
- ldi:
  - T3: grb, ba_out, y_in.
  - T4: c_out, alu_op=ADD, z_in.
  - T5: zlo_out, gra, r_in.
- ld: T3–T4 as ldi, then:
  - T5: zlo_out, mar_in.
  - T6: read, mdr_in.
  - T7: mdr_out, gra, r_in.
- st: T3–T4 as ldi, then:
  - T5: zlo_out, mar_in.
  - T6: gra, r_out, mdr_in.
  - T7: write.
- nop: T3 asserts nothing; then T0.
- halt: at T3 go to HALT.
- Illegal opcode: at T3 go to HALT with fault=1.
- Memory wait states (T1 fetch, T6 ld, T7 st):
  - The state holds and its strobes stay asserted until mem_done=1 is sampled; advance on that edge.
  - mem_done=1 in the first cycle gives a single-cycle step.
  - mem_done outside a wait state is ignored.
  - The wait counter clears on every state change and increments each held cycle.
  - When MEM_WAIT_MAX≠0 and the count reaches MEM_WAIT_MAX-1 without mem_done: go to HALT with fault=1.
- HALT: exited only by reset_n.
- Instruction latency: R/I/ldi 6 cycles, ld/st 8 cycles, nop 4 cycles, each plus memory wait cycles. Retirement is the last execute state.

Optional Feature:
- Macro: CTRL_RETIRE_CNT_EN.
- Defined: retired is a 32-bit counter, reset to 0, +1 on exit from each instruction's final state (including nop; excluding halt and illegal). Wraps 0xFFFFFFFF→0.
- Undefined: retired tied to 0 and no counter flops.

Decomposition:
- Shared package ctrl_pkg: opcode constants, ALU op codes, state enum, instruction field positions (ra 26:23, rb 22:19, rc 18:15, C 18:0).
- Sub-module ctrl_op_decode (combinational): opcode → class (RTYPE, ITYPE, LDI, LD, ST, NOP, HALT, ILLEGAL).

Test Plan:
- Reset with mem_done tied 1 → RST 1 cycle with all strobes 0; T0 on the next edge, pc_out=mar_in=inc_pc=z_in=1.
- ir=add r1,r2,r3 (0x18918000), mem_done=1 → sequence T0..T5 over 6 cycles; T4 alu_op=00011, grc=r_out=1; T5 gra=r_in=1; then T0.
- ld r1,0x10(r2) (0x00900010), mem_done delayed 3 cycles in T6 → T6 held 4 cycles with read=mdr_in=1; T7 gra=r_in=1; retired +1 if enabled.
- stop pulsed during T4 of addi → instruction completes; next T0 edges to HALT, run=0, no further strobes.
- MEM_WAIT_MAX=4, mem_done=0 in T1 → after 4 cycles in T1: HALT, fault=1, read=0.
- Opcode 11111 → T3 then HALT, fault=1; reset_n low mid-HALT → RST immediately, fault=0.
